// File: rtl/perf_pkg.sv
// Shared state encoding, default event-channel indices and sizing helper
// for the performance counter bank.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } perf_state_e;

    localparam int unsigned EVT_INST   = 0;
    localparam int unsigned EVT_IC_REQ = 1;
    localparam int unsigned EVT_IC_HIT = 2;
    localparam int unsigned EVT_DC_REQ = 3;
    localparam int unsigned EVT_DC_HIT = 4;
    localparam int unsigned EVT_STALL  = 5;

    // Read-index width: wide enough to address NUM_EVT events plus the cycle counter.
    function automatic int unsigned idx_width(input int unsigned num_evt);
        return ($clog2(num_evt + 1) > 1) ? $clog2(num_evt + 1) : 1;
    endfunction

endpackage

// File: rtl/perf_cnt_cell.sv
// One counter channel with its sticky overflow flag; saturates or wraps
// at all-ones depending on SAT_MODE.
module perf_cnt_cell #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SAT_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (cnt_q == '1) begin
                ovf_d = 1'b1;
                cnt_d = (SAT_MODE != 0) ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_EVT event counters plus a cycle counter, gated by a small
// run/halt/timeout FSM, with a registered one-cycle read port.
module perf_counter_bank import perf_pkg::*; #(
    parameter int unsigned NUM_EVT    = 6,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned SAT_MODE   = 1,
    parameter int unsigned MAX_CYCLES = 100000,
    localparam int unsigned IDX_W     = idx_width(NUM_EVT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               hlt_i,
    input  logic               clear_i,
    input  logic               rd_req_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic               rd_valid_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_ovf_o,
    output logic               rd_err_o,
    output logic [1:0]         state_o,
    output logic               timeout_o
);

    localparam int unsigned NCH = NUM_EVT + 1;

    perf_state_e      state_q, state_d;
    logic             count_en;
    logic             cyc_hit;
    logic [NCH-1:0]   inc;
    logic [CNT_W-1:0] cnt [NCH];
    logic [NCH-1:0]   ovf;

    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_ovf_q, rd_ovf_d;
    logic             rd_err_q, rd_err_d;

    assign count_en = (state_q == RUN) && enable_i && !clear_i;
    // Top channel is the cycle counter: it counts on every enabled RUN cycle.
    assign inc      = count_en ? {1'b1, evt_i} : '0;
    // Fires on the edge that brings the cycle counter to MAX_CYCLES; a
    // saturated or wrapping counter at all-ones can never reach it.
    assign cyc_hit  = (MAX_CYCLES != 0) && count_en && (cnt[NUM_EVT] != '1) &&
                      (64'(cnt[NUM_EVT]) + 64'd1 == 64'(MAX_CYCLES));

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        perf_cnt_cell #(
            .CNT_W   (CNT_W),
            .SAT_MODE(SAT_MODE)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .clr_i(clear_i),
            .inc_i(inc[g]),
            .cnt_o(cnt[g]),
            .ovf_o(ovf[g])
        );
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable_i) state_d = RUN;
                RUN: begin
                    if (hlt_i)        state_d = HALTED;
                    else if (cyc_hit) state_d = TIMEOUT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        rd_valid_d = rd_req_i;
        rd_data_d  = '0;
        rd_ovf_d   = 1'b0;
        rd_err_d   = 1'b0;
        if (rd_req_i) begin
            if (32'(rd_idx_i) > NUM_EVT) begin
                rd_err_d = 1'b1;
            end else begin
                for (int unsigned k = 0; k < NCH; k++) begin
                    if (32'(rd_idx_i) == k) begin
                        rd_data_d = cnt[k];
                        rd_ovf_d  = ovf[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ovf_q   <= rd_ovf_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_ovf_o   = rd_ovf_q;
    assign rd_err_o   = rd_err_q;
    assign state_o    = state_q;
    assign timeout_o  = (state_q == TIMEOUT);

endmodule

// File: tb/tb_perf_counter_bank.sv
// Three differently parameterised banks share one stimulus stream and are
// compared every cycle against a per-instance behavioural model.
module tb_perf_counter_bank;
    import perf_pkg::*;

    localparam int NE = 6;
    localparam int NI = 3;
    localparam int unsigned CW   [NI] = '{8, 8, 32};
    localparam int unsigned SATM [NI] = '{1, 0, 1};
    localparam longint      MAXC [NI] = '{0, 0, 20};

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i, hlt_i, clear_i, rd_req_i;
    logic [NE-1:0] evt_i;
    logic [2:0]    rd_idx_i;

    logic [NI-1:0] v_o, ovf_o, err_o, to_o;
    logic [1:0]    st_o [NI];
    logic [7:0]    d0, d1;
    logic [31:0]   d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(8), .SAT_MODE(1), .MAX_CYCLES(0)) u_sat (
        .clk(clk), .rst(rst), .enable_i(enable_i), .evt_i(evt_i), .hlt_i(hlt_i),
        .clear_i(clear_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
        .rd_valid_o(v_o[0]), .rd_data_o(d0), .rd_ovf_o(ovf_o[0]), .rd_err_o(err_o[0]),
        .state_o(st_o[0]), .timeout_o(to_o[0]));

    perf_counter_bank #(.NUM_EVT(NE), .CNT_W(8), .SAT_MODE(0), .MAX_CYCLES(0)) u_wrap (
        .clk(clk), .rst(rst), .enable_i(enable_i), .evt_i(evt_i), .hlt_i(hlt_i),
        .clear_i(clear_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
        .rd_valid_o(v_o[1]), .rd_data_o(d1), .rd_ovf_o(ovf_o[1]), .rd_err_o(err_o[1]),
        .state_o(st_o[1]), .timeout_o(to_o[1]));

    perf_counter_bank #(.NUM_EVT(NE), .MAX_CYCLES(20)) u_wdog (
        .clk(clk), .rst(rst), .enable_i(enable_i), .evt_i(evt_i), .hlt_i(hlt_i),
        .clear_i(clear_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
        .rd_valid_o(v_o[2]), .rd_data_o(d2), .rd_ovf_o(ovf_o[2]), .rd_err_o(err_o[2]),
        .state_o(st_o[2]), .timeout_o(to_o[2]));

    // Behavioural model: plain integer counters and a state number per instance.
    longint mcnt [NI][NE+1];
    bit     movf [NI][NE+1];
    int     mst  [NI];
    bit     e_v  [NI];
    longint e_d  [NI];
    bit     e_o  [NI];
    bit     e_e  [NI];

    function automatic void bump(input int i, input int k);
        longint top = (longint'(1) << CW[i]) - 1;
        if (mcnt[i][k] == top) begin
            movf[i][k] = 1'b1;
            if (SATM[i] == 0) mcnt[i][k] = 0;
        end else begin
            mcnt[i][k] = mcnt[i][k] + 1;
        end
    endfunction

    function automatic void zero_inst(input int i);
        for (int k = 0; k <= NE; k++) begin
            mcnt[i][k] = 0;
            movf[i][k] = 1'b0;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                zero_inst(i);
                mst[i] = 0;
                e_v[i] = 1'b0; e_d[i] = 0; e_o[i] = 1'b0; e_e[i] = 1'b0;
            end else begin
                e_v[i] = rd_req_i; e_d[i] = 0; e_o[i] = 1'b0; e_e[i] = 1'b0;
                if (rd_req_i) begin
                    if (int'(rd_idx_i) <= NE) begin
                        e_d[i] = mcnt[i][rd_idx_i];
                        e_o[i] = movf[i][rd_idx_i];
                    end else begin
                        e_e[i] = 1'b1;
                    end
                end
                if (clear_i) begin
                    zero_inst(i);
                    mst[i] = 0;
                end else if (mst[i] == 0) begin
                    if (enable_i) mst[i] = 1;
                end else if (mst[i] == 1) begin
                    if (enable_i) begin
                        for (int k = 0; k < NE; k++) if (evt_i[k]) bump(i, k);
                        bump(i, NE);
                    end
                    if (hlt_i) mst[i] = 2;
                    else if (enable_i && MAXC[i] != 0 && mcnt[i][NE] == MAXC[i]) mst[i] = 3;
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got %0d expected %0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk(nm, -1, act, exp);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [63:0] dat;
            dat = (i == 0) ? 64'(d0) : (i == 1) ? 64'(d1) : 64'(d2);
            chk("rd_valid", i, 64'(v_o[i]), 64'(e_v[i]));
            chk("rd_data", i, dat, e_v[i] ? e_d[i] : 64'd0);
            chk("rd_ovf", i, 64'(ovf_o[i]), 64'(e_v[i] & e_o[i]));
            chk("rd_err", i, 64'(err_o[i]), 64'(e_v[i] & e_e[i]));
            chk("state", i, 64'(st_o[i]), 64'(mst[i]));
            chk("timeout", i, 64'(to_o[i]), 64'(mst[i] == 3));
        end
    end

    task automatic rd(input logic [2:0] idx);
        rd_req_i = 1'b1;
        rd_idx_i = idx;
        @(negedge clk);
        rd_req_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        int pulses;
        rst = 1'b1; enable_i = 1'b0; evt_i = '0; hlt_i = 1'b0;
        clear_i = 1'b0; rd_req_i = 1'b0; rd_idx_i = '0;
        repeat (2) @(negedge clk);
        lit("reset_state", 64'(st_o[0]), 64'(IDLE));
        lit("reset_valid", 64'(v_o), 0);
        lit("reset_timeout", 64'(to_o), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic counting: channels 0 and 2 toggled for 10 cycles.
        enable_i = 1'b1;
        @(negedge clk);
        lit("run_state", 64'(st_o[0]), 64'(RUN));
        evt_i = 6'b000101;
        repeat (10) @(negedge clk);
        enable_i = 1'b0; evt_i = '0;
        rd(3'd0); lit("basic_ch0", 64'(d0), 10); lit("basic_ch0_ovf", 64'(ovf_o[0]), 0);
        rd(3'd2); lit("basic_ch2", 64'(d2), 10); lit("basic_ch2_ovf", 64'(ovf_o[2]), 0);
        rd(3'd1); lit("basic_ch1", 64'(d0), 0);

        // Watchdog: 10 more counted cycles reach MAX_CYCLES=20 on u_wdog.
        enable_i = 1'b1;
        repeat (9) @(negedge clk);
        lit("wdog_pre_state", 64'(st_o[2]), 64'(RUN));
        @(negedge clk);
        lit("wdog_state", 64'(st_o[2]), 64'(TIMEOUT));
        lit("wdog_timeout", 64'(to_o[2]), 1);
        repeat (3) @(negedge clk);
        enable_i = 1'b0;
        rd(3'd6); lit("wdog_cycles", 64'(d2), 20); lit("sat_cycles", 64'(d0), 23);

        // Clear beats halt, events and enable in the same cycle.
        clear_i = 1'b1; hlt_i = 1'b1; evt_i = '1; enable_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0; hlt_i = 1'b0; evt_i = '0; enable_i = 1'b0;
        lit("clear_state", 64'(st_o[0]), 64'(IDLE));
        lit("clear_timeout", 64'(to_o[2]), 0);
        rd(3'd0); lit("clear_ch0", 64'(d2), 0);
        rd(3'd6); lit("clear_cyc", 64'(d0), 0);

        // 300 events on channel 0: saturate vs wrap in 8 bits.
        enable_i = 1'b1;
        @(negedge clk);
        evt_i[EVT_INST] = 1'b1;
        repeat (300) @(negedge clk);
        enable_i = 1'b0; evt_i = '0;
        rd(3'd0);
        lit("sat_val", 64'(d0), 255); lit("sat_ovf", 64'(ovf_o[0]), 1);
        lit("wrap_val", 64'(d1), 44); lit("wrap_ovf", 64'(ovf_o[1]), 1);
        lit("wdog_frozen", 64'(d2), 20);

        // Halt with a coincident event after 4 prior events.
        do_clear();
        enable_i = 1'b1;
        @(negedge clk);
        evt_i = 6'b000001;
        repeat (4) @(negedge clk);
        hlt_i = 1'b1;
        @(negedge clk);
        hlt_i = 1'b0;
        lit("halt_state", 64'(st_o[0]), 64'(HALTED));
        repeat (5) @(negedge clk);
        enable_i = 1'b0; evt_i = '0;
        rd(3'd0); lit("halt_ch0", 64'(d0), 5); lit("halt_ovf", 64'(ovf_o[0]), 0);
        lit("halt_state_kept", 64'(st_o[0]), 64'(HALTED));

        // Out-of-range index (largest encodable) and the boundary in-range index.
        rd(3'd7);
        lit("oor_err", 64'(err_o[0]), 1); lit("oor_data", 64'(d0), 0); lit("oor_ovf", 64'(ovf_o[0]), 0);
        rd(3'd6);
        lit("idx6_err", 64'(err_o[0]), 0); lit("idx6_data", 64'(d0), 5);

        // Reset while a read response is pending.
        rd_req_i = 1'b1; rd_idx_i = 3'd0;
        @(posedge clk);
        #2 rst = 1'b1;
        rd_req_i = 1'b0;
        @(negedge clk);
        lit("rst_kill_valid", 64'(v_o), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (v_o != '0) pulses++;
        end
        lit("rst_no_pulse", pulses, 0);
        lit("rst_state", 64'(st_o[2]), 64'(IDLE));

        // Randomised traffic including back-to-back reads.
        for (int c = 0; c < 600; c++) begin
            enable_i = ($urandom_range(3) != 0);
            evt_i    = NE'($urandom);
            hlt_i    = ($urandom_range(63) == 0);
            clear_i  = ($urandom_range(39) == 0);
            rd_req_i = 1'($urandom_range(1));
            rd_idx_i = 3'($urandom_range(7));
            @(negedge clk);
        end
        rd_req_i = 1'b0; enable_i = 1'b0; clear_i = 1'b0; hlt_i = 1'b0; evt_i = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
